regfile_sequencer: RTL and testbench

- Upstream control stage for the two-entry, 8-bit register file (A = entry 0, B = entry 1).
- Accepts 16-bit instructions over a valid/ready handshake and drives the register file's rw/rsel/wsel/w pins.
- Consumes the file's registered read0/read1, runs one ALU operation and writes the result back through a fixed multi-cycle FSM.
- One instruction in flight; no forwarding needed.

---
 rtl/regfile_seq_pkg.sv | 37 +++
 rtl/seq_alu.sv | 37 +++
 rtl/regfile_sequencer.sv | 105 ++++++++++
 tb/tb_regfile_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared types and instruction field positions for the register-file sequencer.
package regfile_seq_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_AND = 3'b100,
    OP_OR  = 3'b101,
    OP_XOR = 3'b110,
    OP_MOV = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WB
  } state_t;

  localparam int unsigned OP_MSB   = 15;
  localparam int unsigned OP_LSB   = 13;
  localparam int unsigned DST_BIT  = 12;
  localparam int unsigned SRCA_BIT = 11;
  localparam int unsigned SRCB_BIT = 10;
  localparam int unsigned IMM_MSB  = 7;
  localparam int unsigned IMM_LSB  = 0;

  // Only the fields needed after the accept edge are kept in the instruction register.
  typedef struct packed {
    opcode_t    op;
    logic       dst;
    logic [7:0] imm;
  } ir_t;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU: one extra bit of width carries ADD carry / SUB no-borrow.
module seq_alu
  import regfile_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [7:0]       imm,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = '0;
    case (op)
      OP_LDI:  sum = {1'b0, WIDTH'(imm)};
      OP_ADD:  sum = {1'b0, a} + {1'b0, b};
      OP_SUB:  sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
      OP_AND:  sum = {1'b0, a & b};
      OP_OR:   sum = {1'b0, a | b};
      OP_XOR:  sum = {1'b0, a ^ b};
      OP_MOV:  sum = {1'b0, a};
      default: sum = '0;
    endcase
  end

  assign result = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];
  assign zero   = (sum[WIDTH-1:0] == '0);

endmodule

// File: rtl/regfile_sequencer.sv
// Control stage for a two-entry register file: accept, read, execute, write back.
module regfile_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic [15:0]      instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [WIDTH-1:0] read0,
  input  logic [WIDTH-1:0] read1,
  output logic             rw,
  output logic [1:0]       rsel,
  output logic             wsel,
  output logic [WIDTH-1:0] w,
  output logic             done,
  output logic             busy,
  output logic             flag_z,
  output logic             flag_c
);

  state_t           state, state_next;
  ir_t              ir;
  logic             nop_done;
  logic             accept;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             unused_rsvd;

  assign in_op       = instr[OP_MSB -: OPW];
  assign accept      = instr_valid && (state == S_IDLE);
  assign unused_rsvd = ^instr[9:8];

  assign instr_ready = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign rw          = (state == S_WB);
  assign done        = (state == S_WB) || nop_done;

  always_ff @(posedge sysclk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (in_op == OP_LDI)      state_next = S_EXEC;
          else if (in_op != OP_NOP) state_next = S_READ;
        end
      end
      S_READ:  state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      ir       <= '0;
      rsel     <= '0;
      wsel     <= 1'b0;
      w        <= '0;
      flag_z   <= 1'b0;
      flag_c   <= 1'b0;
      nop_done <= 1'b0;
    end else begin
      nop_done <= accept && (in_op == OP_NOP);
      if (accept && (in_op != OP_NOP)) begin
        ir.op  <= opcode_t'(instr[OP_MSB:OP_LSB]);
        ir.dst <= instr[DST_BIT];
        ir.imm <= instr[IMM_MSB:IMM_LSB];
        // rsel is driven from the accept edge so it is already stable during READ
        if (in_op != OP_LDI) rsel <= {~instr[SRCB_BIT], ~instr[SRCA_BIT]};
      end
      if (state == S_EXEC) begin
        w      <= alu_result;
        wsel   <= ir.dst;
        flag_z <= alu_zero;
        if ((ir.op == OP_ADD) || (ir.op == OP_SUB)) flag_c <= alu_carry;
      end
    end
  end

  seq_alu #(
    .WIDTH (WIDTH),
    .OPW   (OPW)
  ) u_alu (
    .op     (ir.op),
    .a      (read0),
    .b      (read1),
    .imm    (ir.imm),
    .result (alu_result),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed plan plus random instructions against a reference model.
module tb_regfile_sequencer;

  logic        sysclk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  read0, read1;
  logic        rw;
  logic [1:0]  rsel;
  logic        wsel;
  logic [7:0]  w;
  logic        done, busy, flag_z, flag_c;

  int ntests = 0;
  int nfail  = 0;

  int unsigned m_reg [2] = '{0, 0};
  int unsigned m_w = 0, m_wsel = 0, m_z = 0, m_c = 0;

  logic [7:0] rf [2] = '{8'h00, 8'h00};

  always #5 sysclk = ~sysclk;

  regfile_sequencer #(.WIDTH(8), .OPW(3)) dut (
    .sysclk      (sysclk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .read0       (read0),
    .read1       (read1),
    .rw          (rw),
    .rsel        (rsel),
    .wsel        (wsel),
    .w           (w),
    .done        (done),
    .busy        (busy),
    .flag_z      (flag_z),
    .flag_c      (flag_c)
  );

  // Register file environment: registered reads, write at the rising edge while rw=1.
  always @(posedge sysclk) begin
    if (rw) rf[wsel] <= w;
    read0 <= rsel[0] ? rf[0] : rf[1];
    read1 <= rsel[1] ? rf[0] : rf[1];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int unsigned op, input int unsigned dst,
                                     input int unsigned sa, input int unsigned sb,
                                     input int unsigned imm);
    int unsigned rsv;
    rsv = $urandom;
    return {op[2:0], dst[0], sa[0], sb[0], rsv[1:0], imm[7:0]};
  endfunction

  function automatic logic [15:0] rand_instr();
    return mk($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 1), $urandom_range(0, 255));
  endfunction

  // Issues one instruction from IDLE and follows it to retirement.
  task automatic issue(input logic [15:0] ins, input bit hold, input logic [15:0] nxt);
    int unsigned op, dst, sa, sb, imm, a, b, r, lat, exp_rsel;
    bit alu;
    op  = ins[15:13];
    dst = ins[12];
    sa  = ins[11];
    sb  = ins[10];
    imm = ins[7:0];
    @(negedge sysclk);
    check("rf_A", rf[0], m_reg[0]);
    check("rf_B", rf[1], m_reg[1]);
    check("ready_idle", instr_ready, 1);
    instr       = ins;
    instr_valid = 1'b1;

    a   = m_reg[sa];
    b   = m_reg[sb];
    alu = (op >= 2);
    lat = (op == 0) ? 1 : (op == 1) ? 2 : 3;
    exp_rsel = {(sb == 0), (sa == 0)};
    case (op)
      1:       r = imm;
      2:       r = a + b;
      3:       r = a + 256 - b;
      4:       r = a & b;
      5:       r = a | b;
      6:       r = a ^ b;
      7:       r = a;
      default: r = 0;
    endcase
    if (op == 2) m_c = (r > 255);
    if (op == 3) m_c = (a >= b);
    r = r % 256;
    if (op != 0) begin
      m_w    = r;
      m_wsel = dst;
      m_z    = (r == 0);
    end

    @(posedge sysclk);
    for (int cyc = 1; cyc <= lat; cyc++) begin
      @(negedge sysclk);
      check("done", done, (cyc == lat));
      check("busy", busy, (op != 0));
      check("ready", instr_ready, (op == 0));
      check("rw", rw, (op != 0) && (cyc == lat));
      if (alu) check("rsel", rsel, exp_rsel);
      if (cyc == lat) begin
        check("w", w, m_w);
        check("wsel", wsel, m_wsel);
        check("flag_z", flag_z, m_z);
        check("flag_c", flag_c, m_c);
      end
      if (cyc == 1) begin
        if (hold) instr = nxt;
        else      instr_valid = 1'b0;
      end
    end
    if (op != 0) m_reg[dst] = r;
  endtask

  initial begin
    logic [15:0] cur, nxt, xor_i;
    rst         = 1'b1;
    instr       = '0;
    instr_valid = 1'b0;
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_rw", rw, 0);
    check("rst_rsel", rsel, 0);
    check("rst_wsel", wsel, 0);
    check("rst_w", w, 0);
    check("rst_done", done, 0);
    check("rst_busy", busy, 0);
    check("rst_z", flag_z, 0);
    check("rst_c", flag_c, 0);
    check("rst_ready", instr_ready, 1);
    rst = 1'b0;

    issue(mk(1, 0, 0, 0, 8'h2A), 0, '0);
    issue(mk(1, 0, 0, 0, 8'hF0), 0, '0);
    issue(mk(1, 1, 0, 0, 8'h20), 0, '0);
    issue(mk(2, 1, 0, 1, 0), 0, '0);
    issue(mk(1, 0, 0, 0, 8'h55), 0, '0);
    issue(mk(3, 0, 0, 0, 0), 0, '0);
    issue(mk(1, 0, 0, 0, 8'h01), 0, '0);
    issue(mk(1, 1, 0, 0, 8'h02), 0, '0);
    issue(mk(3, 0, 0, 1, 0), 0, '0);

    xor_i = mk(6, 1, 0, 1, 0);
    issue(mk(2, 0, 0, 1, 0), 1, xor_i);
    issue(xor_i, 0, '0);

    issue(mk(1, 1, 0, 0, 8'h11), 0, '0);
    @(negedge sysclk);
    check("rf_A_pre_rst", rf[0], m_reg[0]);
    check("rf_B_pre_rst", rf[1], m_reg[1]);
    instr       = mk(2, 0, 0, 1, 0);
    instr_valid = 1'b1;
    @(posedge sysclk);
    @(negedge sysclk);
    instr_valid = 1'b0;
    check("abort_read_busy", busy, 1);
    @(negedge sysclk);
    rst = 1'b1;
    @(negedge sysclk);
    check("abort_ready", instr_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_rw", rw, 0);
    check("abort_done", done, 0);
    check("abort_z", flag_z, 0);
    check("abort_c", flag_c, 0);
    check("abort_w", w, 0);
    check("abort_wsel", wsel, 0);
    check("abort_rsel", rsel, 0);
    rst    = 1'b0;
    m_w    = 0;
    m_wsel = 0;
    m_z    = 0;
    m_c    = 0;
    issue(mk(1, 1, 0, 0, 8'h7C), 0, '0);

    issue(mk(0, 1, 1, 1, 8'hFF), 0, '0);

    cur = rand_instr();
    for (int i = 0; i < 60; i++) begin
      nxt = rand_instr();
      issue(cur, (cur[15:13] != 3'b000) && ($urandom_range(0, 1) == 1), nxt);
      cur = nxt;
    end

    @(negedge sysclk);
    check("rf_A_final", rf[0], m_reg[0]);
    check("rf_B_final", rf[1], m_reg[1]);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
